// File: rtl/udc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udc_pkg
// Description : Shared types and elaboration helpers for the modulo-N
//               up/down counter (updn_counter_mod). Optional feature macro
//               used by the counter: UDC_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package udc_pkg;

  // Bound behaviour selected by the sat_mode input
  typedef enum logic {
    UDC_WRAP = 1'b0,
    UDC_SAT  = 1'b1
  } udc_mode_e;

  // Narrowest counter that still has distinct min/max/interior values
  localparam int c_udc_min_width = 2;

  // True when the modulus is legal and all of 0..modulus-1 fit in width bits
  function automatic bit udc_mod_fits(input int width, input int modulus);
    return (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

endpackage : udc_pkg
`default_nettype wire

// File: rtl/udc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : udc_next_calc
// Description : Combinational next-count calculator for updn_counter_mod.
//               Given the current count, step, direction and bound mode it
//               produces the next count plus wrap/saturate events. All
//               arithmetic is carried in WIDTH+1 bits so that a carry or
//               borrow past the modulus is never silently dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module udc_next_calc
  import udc_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 2**WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             down,
  input  udc_mode_e        mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_ev,
  output logic             sat_ev
);

  localparam logic [WIDTH:0] c_mod = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] w_count_x;
  logic [WIDTH:0] w_step_x;
  logic [WIDTH:0] w_step_red;
  logic [WIDTH:0] w_sum_red;
  logic [WIDTH:0] w_sum_raw;
  logic [WIDTH:0] w_diff_wrap;

  assign w_count_x  = {1'b0, count};
  assign w_step_x   = {1'b0, step};

  // In wrap mode a step of MOD or more is equivalent to its residue; the
  // reduction collapses to a wire when MOD is a power of two covering step.
  assign w_step_red = w_step_x % c_mod;

  // count < MOD and step_red < MOD, so the sum stays below 2*MOD <= 2**(WIDTH+1)
  assign w_sum_red  = w_count_x + w_step_red;

  // Saturating paths compare against the unreduced step
  assign w_sum_raw  = w_count_x + w_step_x;

  // Borrow-wrap result, only selected when count < step_red, so it lands in 0..MOD-1
  assign w_diff_wrap = w_count_x + c_mod - w_step_red;

  // Select next value and bound events for the requested direction and mode
  always_comb begin
    nxt     = count;
    wrap_ev = 1'b0;
    sat_ev  = 1'b0;
    if (mode == UDC_WRAP) begin
      if (!down) begin
        if (w_sum_red >= c_mod) begin
          nxt     = WIDTH'(w_sum_red - c_mod);
          wrap_ev = 1'b1;
        end else begin
          nxt     = w_sum_red[WIDTH-1:0];
        end
      end else begin
        if (w_count_x < w_step_red) begin
          nxt     = w_diff_wrap[WIDTH-1:0];
          wrap_ev = 1'b1;
        end else begin
          nxt     = WIDTH'(w_count_x - w_step_red);
        end
      end
    end else begin
      if (!down) begin
        if (w_sum_raw > c_max) begin
          nxt    = c_max[WIDTH-1:0];
          sat_ev = 1'b1;
        end else begin
          nxt    = w_sum_raw[WIDTH-1:0];
        end
      end else begin
        if (w_count_x < w_step_x) begin
          nxt    = '0;
          sat_ev = 1'b1;
        end else begin
          nxt    = WIDTH'(w_count_x - w_step_x);
        end
      end
    end
  end

endmodule : udc_next_calc
`default_nettype wire

// File: rtl/updn_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : updn_counter_mod
// Description : Parametrised modulo-MOD up/down counter with enable,
//               synchronous load (clamped to MOD-1), wrap or saturate
//               behaviour at the bounds, a registered wrap pulse, a
//               registered saturation level and combinational at_max /
//               at_min flags. Priority per edge: rst > load > en.
//               Optional macro UDC_STEP_EN adds a 'step' input port that
//               sets the increment/decrement size; without it the step is
//               fixed at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module updn_counter_mod
  import udc_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MOD     = 2**WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDC_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0]   c_mod     = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] c_max     = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

  // Parameter legality checks, evaluated at elaboration
  if (WIDTH < c_udc_min_width) begin : g_chk_width
    $error("updn_counter_mod: WIDTH=%0d is below the minimum of %0d", WIDTH, c_udc_min_width);
  end

  if (!udc_mod_fits(WIDTH, MOD)) begin : g_chk_mod
    $error("updn_counter_mod: MOD=%0d must be in 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
  end

  if ((RST_VAL < 0) || (RST_VAL >= MOD)) begin : g_chk_rst_val
    $error("updn_counter_mod: RST_VAL=%0d must be below MOD=%0d", RST_VAL, MOD);
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap_ev;
  logic             w_sat_ev;
  logic [WIDTH-1:0] w_load_clamped;
  udc_mode_e        w_mode;

`ifdef UDC_STEP_EN
  assign w_step = step;
`else
  assign w_step = WIDTH'(1);
`endif

  assign w_mode = udc_mode_e'(sat_mode);

  // Out-of-range load values pin to the top of the count range
  assign w_load_clamped = ({1'b0, load_val} >= c_mod) ? c_max : load_val;

  udc_next_calc #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next_calc (
    .count   (r_count),
    .step    (w_step),
    .down    (down),
    .mode    (w_mode),
    .nxt     (w_nxt),
    .wrap_ev (w_wrap_ev),
    .sat_ev  (w_sat_ev)
  );

  // Count register with rst > load > en priority; wrap is a one-cycle pulse, sat is a held level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_rst_val;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
    end else if (en) begin
      r_count <= w_nxt;
      r_wrap  <= w_wrap_ev;
      r_sat   <= w_sat_ev;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count  = r_count;
  assign wrap   = r_wrap;
  assign sat    = r_sat;
  assign at_max = (r_count == c_max);
  assign at_min = (r_count == '0);

endmodule : updn_counter_mod
`default_nettype wire
